// File: rtl/instruction_encoder.sv
// instruction_encoder: packs opcode/register/immediate fields into 32-bit IR
// words, buffers them in a small FIFO and writes them to instruction memory at
// sequential addresses, throttled by the memory-ready signal.
//
// Ports:
//   i_clk, i_reset_n   clock (rising edge), async active-low reset
//   i_clear            sync flush: FIFO empty, addr=0, illegal count=0, LOAD
//   i_valid/o_ready    field-set handshake
//   i_opcode, i_rd, i_rs1, i_rs2, i_imm   instruction fields
//   i_finish           stop accepting, drain FIFO, then DONE
//   o_mem_we, i_mem_ready, o_mem_addr, o_mem_data   memory write port
//   o_illegal_cnt      saturating count of illegal opcodes accepted
//   o_done             high in DONE
module instruction_encoder #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_clear,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [7:0]        i_opcode,
  input  logic [3:0]        i_rd,
  input  logic [3:0]        i_rs1,
  input  logic [3:0]        i_rs2,
  input  logic [15:0]       i_imm,
  input  logic              i_finish,
  output logic              o_mem_we,
  input  logic              i_mem_ready,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_data,
  output logic [7:0]        o_illegal_cnt,
  output logic              o_done
);

  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PTR_W  = IDX_W + 1;
  localparam int unsigned WORD_W = 32;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_LW  = 8'h01;
  localparam logic [7:0] OP_SW  = 8'h02;
  localparam logic [7:0] OP_ADD = 8'h03;
  localparam logic [7:0] OP_SUB = 8'h04;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [7:0]        CNT_MAX   = 8'hFF;

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;

  logic [WORD_W-1:0]  fifo_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic               empty;
  logic               full;

  logic [WORD_W-1:0]  enc_word;
  logic               enc_illegal;

  logic               push;
  logic               pop;
  logic               last_write;

  // FIFO status from extended pointers
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                 (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);

  assign push       = i_valid && o_ready;
  assign pop        = o_mem_we && i_mem_ready;
  assign last_write = pop && (o_mem_addr == LAST_ADDR);

  assign o_mem_data = fifo_q[rd_ptr_q[IDX_W-1:0]];

  // Field packing; unknown opcodes become NOP and are flagged
  always_comb begin
    enc_word    = '0;
    enc_illegal = 1'b0;
    case (i_opcode)
      OP_NOP:  enc_word = '0;
      OP_LW:   enc_word = {OP_LW, i_rd, 4'h0, i_imm};
      OP_SW:   enc_word = {OP_SW, i_rs1, 4'h0, i_imm};
      OP_ADD:  enc_word = {OP_ADD, i_rd, 12'h000, i_rs1, i_rs2};
      OP_SUB:  enc_word = {OP_SUB, i_rd, 12'h000, i_rs1, i_rs2};
      default: enc_illegal = 1'b1;
    endcase
  end

  // State register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; clear overrides everything
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD: begin
        if (last_write) begin
          state_d = S_DONE;
        end else if (i_finish) begin
          // A word accepted alongside finish still has to be drained
          state_d = (empty && !push) ? S_DONE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (last_write || empty) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_LOAD;
    endcase
    if (i_clear) begin
      state_d = S_LOAD;
    end
  end

  // Handshake and status outputs
  always_comb begin
    o_ready  = 1'b0;
    o_mem_we = 1'b0;
    o_done   = 1'b0;
    o_ready  = (state_q == S_LOAD) && !full && !i_clear;
    o_mem_we = !empty && (state_q != S_DONE);
    o_done   = (state_q == S_DONE);
  end

  // FIFO storage, write address and illegal-opcode counter
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      o_mem_addr    <= '0;
      o_illegal_cnt <= '0;
    end else if (i_clear) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      o_mem_addr    <= '0;
      o_illegal_cnt <= '0;
    end else begin
      if (last_write) begin
        // Memory is full: whatever is still buffered is dropped
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) begin
          fifo_q[wr_ptr_q[IDX_W-1:0]] <= enc_word;
          wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
      end
      if (pop && (o_mem_addr != LAST_ADDR)) begin
        o_mem_addr <= o_mem_addr + ADDR_W'(1);
      end
      if (push && enc_illegal && (o_illegal_cnt != CNT_MAX)) begin
        o_illegal_cnt <= o_illegal_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed bench for instruction_encoder: one default instance (ADDR_W=8) and
// one small-memory instance (ADDR_W=2) sharing the same stimulus.
module tb_instruction_encoder;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        valid;
  logic [7:0]  opcode;
  logic [3:0]  rd;
  logic [3:0]  rs1;
  logic [3:0]  rs2;
  logic [15:0] imm;
  logic        finish;
  logic        mem_ready;

  logic        ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_data;
  logic [7:0]  illegal_cnt;
  logic        done;

  logic        ready2;
  logic        mem_we2;
  logic [1:0]  mem_addr2;
  logic [31:0] mem_data2;
  logic [7:0]  illegal_cnt2;
  logic        done2;

  int n_checks;
  int n_pass;

  instruction_encoder #(.DEPTH(4), .ADDR_W(8)) u_dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_clear(clear), .i_valid(valid),
    .o_ready(ready), .i_opcode(opcode), .i_rd(rd), .i_rs1(rs1), .i_rs2(rs2),
    .i_imm(imm), .i_finish(finish), .o_mem_we(mem_we), .i_mem_ready(mem_ready),
    .o_mem_addr(mem_addr), .o_mem_data(mem_data), .o_illegal_cnt(illegal_cnt),
    .o_done(done)
  );

  instruction_encoder #(.DEPTH(4), .ADDR_W(2)) u_dut_small (
    .i_clk(clk), .i_reset_n(rst_n), .i_clear(clear), .i_valid(valid),
    .o_ready(ready2), .i_opcode(opcode), .i_rd(rd), .i_rs1(rs1), .i_rs2(rs2),
    .i_imm(imm), .i_finish(finish), .o_mem_we(mem_we2), .i_mem_ready(mem_ready),
    .o_mem_addr(mem_addr2), .o_mem_data(mem_data2), .o_illegal_cnt(illegal_cnt2),
    .o_done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] op, input logic [3:0] f_rd, input logic [3:0] f_rs1,
                       input logic [3:0] f_rs2, input logic [15:0] f_imm);
    opcode = op;
    rd     = f_rd;
    rs1    = f_rs1;
    rs2    = f_rs2;
    imm    = f_imm;
  endtask

  // Present a field set and wait (bounded) until the main instance accepts it
  task automatic send(input logic [7:0] op, input logic [3:0] f_rd, input logic [3:0] f_rs1,
                      input logic [3:0] f_rs2, input logic [15:0] f_imm);
    int accepted;
    accepted = 0;
    drive(op, f_rd, f_rs1, f_rs2, f_imm);
    valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ready) begin
        accepted = 1;
        break;
      end
    end
    check("send_accept", 32'(accepted), 32'd1);
    tick();
    valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  logic [31:0] exp_small [6];
  int          acc;
  int          writes;

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    clear     = 1'b0;
    valid     = 1'b0;
    finish    = 1'b0;
    mem_ready = 1'b0;
    drive(8'h00, 4'h0, 4'h0, 4'h0, 16'h0000);

    // Reset state
    #12;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_data", mem_data, 32'h0);
    check("rst_cnt", 32'(illegal_cnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1: ADD encoding, write one cycle after accept
    mem_ready = 1'b1;
    send(8'h03, 4'd3, 4'd1, 4'd2, 16'hFFFF);
    @(negedge clk);
    check("add_we", 32'(mem_we), 32'd1);
    check("add_addr", 32'(mem_addr), 32'd0);
    check("add_data", mem_data, 32'h0330_0012);
    @(negedge clk);
    check("add_addr_after", 32'(mem_addr), 32'd1);
    check("add_we_after", 32'(mem_we), 32'd0);
    tick();

    // 2: LW then SW, sequential addresses
    do_clear();
    mem_ready = 1'b0;
    send(8'h01, 4'd5, 4'd9, 4'd9, 16'h0010);
    send(8'h02, 4'd9, 4'd7, 4'd9, 16'hBEEF);
    @(negedge clk);
    check("lw_addr", 32'(mem_addr), 32'd0);
    check("lw_data", mem_data, 32'h0150_0010);
    check("hold_we", 32'(mem_we), 32'd1);
    @(negedge clk);
    check("hold_data", mem_data, 32'h0150_0010);
    mem_ready = 1'b1;
    @(negedge clk);
    check("sw_addr", 32'(mem_addr), 32'd1);
    check("sw_data", mem_data, 32'h0270_BEEF);
    @(negedge clk);
    check("sw_addr_after", 32'(mem_addr), 32'd2);
    tick();

    // 3: illegal opcode encodes as NOP and counts, then saturation
    do_clear();
    send(8'h09, 4'hF, 4'hF, 4'hF, 16'hFFFF);
    @(negedge clk);
    check("ill_data", mem_data, 32'h0000_0000);
    check("ill_cnt", 32'(illegal_cnt), 32'd1);
    tick();
    do_clear();
    acc = 0;
    drive(8'h09, 4'h1, 4'h2, 4'h3, 16'h1234);
    valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (ready) acc++;
      if (acc == 256) break;
    end
    tick();
    valid = 1'b0;
    check("ill_accepts", 32'(acc), 32'd256);
    @(negedge clk);
    check("ill_sat", 32'(illegal_cnt), 32'd255);
    tick();

    // 4: back-pressure with a full FIFO, ordered drain
    do_clear();
    mem_ready = 1'b0;
    send(8'h02, 4'h0, 4'd1, 4'h0, 16'h1111);
    send(8'h02, 4'h0, 4'd2, 4'h0, 16'h2222);
    send(8'h02, 4'h0, 4'd3, 4'h0, 16'h3333);
    send(8'h02, 4'h0, 4'd4, 4'h0, 16'h4444);
    drive(8'h02, 4'h0, 4'd5, 4'h0, 16'h5555);
    valid = 1'b1;
    @(negedge clk);
    check("full_ready", 32'(ready), 32'd0);
    check("full_addr0", 32'(mem_addr), 32'd0);
    check("full_data0", mem_data, 32'h0210_1111);
    mem_ready = 1'b1;
    @(negedge clk);
    check("full_ready_again", 32'(ready), 32'd1);
    check("full_addr1", 32'(mem_addr), 32'd1);
    check("full_data1", mem_data, 32'h0220_2222);
    tick();
    valid = 1'b0;
    @(negedge clk);
    check("full_addr2", 32'(mem_addr), 32'd2);
    check("full_data2", mem_data, 32'h0230_3333);
    @(negedge clk);
    check("full_addr3", 32'(mem_addr), 32'd3);
    check("full_data3", mem_data, 32'h0240_4444);
    @(negedge clk);
    check("full_addr4", 32'(mem_addr), 32'd4);
    check("full_data4", mem_data, 32'h0250_5555);
    @(negedge clk);
    check("full_empty_we", 32'(mem_we), 32'd0);
    check("full_addr5", 32'(mem_addr), 32'd5);
    tick();

    // 5: finish with stalled memory, drain, DONE, then clear
    do_clear();
    mem_ready = 1'b0;
    send(8'h03, 4'd1, 4'd2, 4'd3, 16'h0000);
    send(8'h04, 4'd4, 4'd5, 4'd6, 16'h0000);
    finish = 1'b1;
    tick();
    finish = 1'b0;
    @(negedge clk);
    check("fin_ready", 32'(ready), 32'd0);
    check("fin_done_early", 32'(done), 32'd0);
    check("fin_data0", mem_data, 32'h0310_0023);
    mem_ready = 1'b1;
    @(negedge clk);
    check("fin_addr1", 32'(mem_addr), 32'd1);
    check("fin_data1", mem_data, 32'h0440_0056);
    @(negedge clk);
    check("fin_we_off", 32'(mem_we), 32'd0);
    @(negedge clk);
    check("fin_done", 32'(done), 32'd1);
    check("fin_addr2", 32'(mem_addr), 32'd2);
    check("fin_done_ready", 32'(ready), 32'd0);
    tick();
    do_clear();
    @(negedge clk);
    check("clr_addr", 32'(mem_addr), 32'd0);
    check("clr_ready", 32'(ready), 32'd1);
    check("clr_done", 32'(done), 32'd0);
    tick();

    // 6: small memory fills after four writes, remaining words dropped
    do_clear();
    exp_small[0] = 32'h0100_0000;
    exp_small[1] = 32'h0110_0001;
    exp_small[2] = 32'h0120_0002;
    exp_small[3] = 32'h0130_0003;
    exp_small[4] = 32'h0140_0004;
    exp_small[5] = 32'h0150_0005;
    writes = 0;
    mem_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k < 6) begin
        drive(8'h01, 4'(k), 4'h0, 4'h0, 16'(k));
        valid = 1'b1;
      end else begin
        valid = 1'b0;
      end
      @(negedge clk);
      if (mem_we2 && writes < 6) begin
        check("small_addr", 32'(mem_addr2), 32'(writes));
        check("small_data", mem_data2, exp_small[writes]);
        writes++;
      end
      tick();
    end
    valid = 1'b0;
    check("small_writes", 32'(writes), 32'd4);
    check("small_done", 32'(done2), 32'd1);
    check("small_addr_last", 32'(mem_addr2), 32'd3);
    check("small_we_off", 32'(mem_we2), 32'd0);

    // Asynchronous reset in the middle of a stream
    do_clear();
    send(8'h03, 4'd1, 4'd1, 4'd1, 16'h0000);
    send(8'h0A, 4'd1, 4'd1, 4'd1, 16'h0000);
    mem_ready = 1'b0;
    send(8'h01, 4'd2, 4'd0, 4'd0, 16'h00AA);
    @(negedge clk);
    check("pre_rst_cnt", 32'(illegal_cnt), 32'd1);
    check("pre_rst_we", 32'(mem_we), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ready", 32'(ready), 32'd1);
    check("arst_we", 32'(mem_we), 32'd0);
    check("arst_addr", 32'(mem_addr), 32'd0);
    check("arst_data", mem_data, 32'h0);
    check("arst_cnt", 32'(illegal_cnt), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_small_done", 32'(done2), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
